// File: rtl/dmac_read_mc.sv
// Multi-channel DMA read engine: splits channel-tagged commands into AXI4 read bursts
// and returns read data tagged with channel, command-final-last and sticky error.
module dmac_read_mc #(
    parameter int ADDR_WD         = 32,
    parameter int DATA_WD         = 32,
    parameter int CHANNEL_COUNT   = 8,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4,
    localparam int STRB_WD        = DATA_WD / 8,
    localparam int CH_WD          = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CH_WD-1:0]   cmd_ch,
    input  logic [ADDR_WD-1:0] cmd_src_addr,
    input  logic [1:0]         cmd_burst,
    input  logic [ADDR_WD-1:0] cmd_beats,
    output logic               data_out_valid,
    input  logic               data_out_ready,
    output logic [DATA_WD-1:0] data_out,
    output logic [CH_WD-1:0]   data_out_ch,
    output logic               data_out_last,
    output logic               data_out_err,
    output logic               m_axi_arvalid,
    output logic [ADDR_WD-1:0] m_axi_araddr,
    output logic [7:0]         m_axi_arlen,
    output logic [2:0]         m_axi_arsize,
    output logic [1:0]         m_axi_arburst,
    input  logic               m_axi_arready,
    input  logic               m_axi_rvalid,
    input  logic [DATA_WD-1:0] m_axi_rdata,
    input  logic [1:0]         m_axi_rresp,
    input  logic               m_axi_rlast,
    output logic               m_axi_rready
);
    localparam int SZ      = $clog2(STRB_WD);
    localparam int PW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int FIX_MAX = (MAX_BURST_LEN < 16) ? MAX_BURST_LEN : 16;

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef struct packed {
        logic [CH_WD-1:0] ch;
        logic             fin;
    } tag_t;

    state_t             state;
    logic [ADDR_WD-1:0] addr;
    logic [ADDR_WD-1:0] remaining;
    logic               fixed;
    logic [CH_WD-1:0]   ch;
    tag_t               fifo [2**PW];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      fifo_count;
    logic               err_sticky;

    logic        fifo_empty, ar_hs, r_hs, pop, fin;
    logic [12:0] b4k;
    logic [8:0]  n;
    tag_t        head;
    logic        rresp_unused;

    // Burst size: remaining beats, length cap, and (INCR only) beats left in the 4 KB page
    always_comb begin
        b4k = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
        n   = fixed ? 9'(FIX_MAX) : 9'(MAX_BURST_LEN);
        if (!fixed && {4'd0, n} > b4k) n = b4k[8:0];
        if (ADDR_WD'(n) > remaining)   n = remaining[8:0];
    end

    assign fin          = (remaining == ADDR_WD'(n));
    assign fifo_empty   = (fifo_count == '0);
    assign head         = fifo[rd_ptr];
    assign ar_hs        = m_axi_arvalid && m_axi_arready;
    assign r_hs         = m_axi_rvalid && m_axi_rready;
    assign pop          = r_hs && m_axi_rlast;
    assign rresp_unused = m_axi_rresp[0];

    assign cmd_ready     = (state == IDLE);
    assign m_axi_arvalid = (state == ISSUE) && (fifo_count < CW'(MAX_OUTSTANDING));
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = 8'(n - 9'd1);
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = fixed ? 2'b00 : 2'b01;

    // R beats without a pending tag are never accepted
    assign m_axi_rready   = data_out_ready && !fifo_empty;
    assign data_out_valid = m_axi_rvalid && !fifo_empty;
    assign data_out       = m_axi_rdata;
    assign data_out_ch    = head.ch;
    assign data_out_last  = m_axi_rlast && !fifo_empty && head.fin;
    assign data_out_err   = err_sticky | (m_axi_rresp[1] && !fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            fixed      <= 1'b0;
            ch         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            err_sticky <= 1'b0;
            for (int i = 0; i < 2**PW; i++) fifo[i] <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    addr      <= cmd_src_addr & ~ADDR_WD'(STRB_WD - 1);
                    remaining <= cmd_beats;
                    fixed     <= (cmd_burst == 2'b00);
                    ch        <= cmd_ch;
                    if (cmd_beats != '0) state <= ISSUE;
                end
                ISSUE: if (ar_hs) begin
                    if (!fixed) addr <= addr + (ADDR_WD'(n) << SZ);
                    remaining      <= remaining - ADDR_WD'(n);
                    fifo[wr_ptr]   <= '{ch: ch, fin: fin};
                    wr_ptr         <= wr_ptr + PW'(1);
                    if (fin) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({ar_hs, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase

            if (r_hs) begin
                if (data_out_last)      err_sticky <= 1'b0;
                else if (m_axi_rresp[1]) err_sticky <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dmac_read_mc.sv
// Scoreboard bench for dmac_read_mc: directed commands, a simple in-order AXI read slave,
// and monitors that pop expected AR and data beats as the DUT presents them.
module tb_dmac_read_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_ch = '0;
    logic [31:0] cmd_src_addr = '0;
    logic [1:0]  cmd_burst = 2'b01;
    logic [31:0] cmd_beats = '0;
    logic        data_out_valid;
    logic        data_out_ready = 1'b1;
    logic [31:0] data_out;
    logic [2:0]  data_out_ch;
    logic        data_out_last, data_out_err;
    logic        m_axi_arvalid;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arready = 1'b1;
    logic        m_axi_rvalid = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rready;

    dmac_read_mc dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
        .cmd_src_addr(cmd_src_addr), .cmd_burst(cmd_burst), .cmd_beats(cmd_beats),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out(data_out), .data_out_ch(data_out_ch),
        .data_out_last(data_out_last), .data_out_err(data_out_err),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] burst; } ar_t;
    typedef struct { logic [31:0] data; logic [2:0] ch; logic last; logic err; } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_d[$];
    int    burst_q[$];
    int    ar_cycle[$];
    int    n_cmp = 0, n_err = 0;
    int    cyc = 0, ar_seen = 0, d_seen = 0;
    int    r_idx = 0, exp_idx = 0, cur_rem = 0, err_at = -1, first_rlast_cyc = -1;
    bit    r_en = 1'b1, rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
        exp_ar.push_back('{addr: a, len: len, burst: b});
    endtask

    task automatic push_beats(input logic [2:0] c, input int beats, input int err_from);
        for (int i = 0; i < beats; i++) begin
            exp_d.push_back('{data: 32'hA000_0000 + 32'(exp_idx), ch: c,
                              last: (i == beats - 1), err: (err_from >= 0 && i >= err_from)});
            exp_idx++;
        end
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [31:0] a, input logic [1:0] b,
                            input logic [31:0] beats);
        int k = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_ch = c; cmd_src_addr = a; cmd_burst = b; cmd_beats = beats;
        do begin @(negedge clk); k++; end while (!cmd_ready && k < 2000);
        if (!cmd_ready) begin n_cmp++; n_err++; $display("FAIL cmd_accept_timeout: got no cmd_ready"); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_d.size() != 0 || exp_ar.size() != 0) && k < 5000) begin
            @(negedge clk); k++;
        end
        if (k >= 5000) begin
            n_cmp++; n_err++;
            $display("FAIL %s_drain: got %0d beats / %0d ARs pending want 0", name, exp_d.size(), exp_ar.size());
        end
        repeat (4) @(negedge clk);
    endtask

    // AXI read slave: bursts returned in order, rdata is a running beat index
    initial forever begin
        bit arh, rh, rl;
        @(negedge clk);
        arh = rst_n && m_axi_arvalid && m_axi_arready;
        rh  = rst_n && m_axi_rvalid && m_axi_rready;
        rl  = m_axi_rlast;
        if (arh) burst_q.push_back(int'(m_axi_arlen) + 1);
        if (rh && rl && first_rlast_cyc < 0) first_rlast_cyc = cyc;
        @(posedge clk); #1;
        if (rh) begin r_idx++; cur_rem--; end
        if (cur_rem == 0 && r_en && burst_q.size() > 0) cur_rem = burst_q.pop_front();
        m_axi_rvalid   = r_en && (cur_rem > 0);
        m_axi_rlast    = (cur_rem == 1);
        m_axi_rdata    = 32'hA000_0000 + 32'(r_idx);
        m_axi_rresp    = (r_idx == err_at) ? 2'b10 : 2'b00;
        data_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // AR monitor
    initial forever begin
        ar_t a;
        @(negedge clk);
        if (rst_n && m_axi_arvalid && m_axi_arready) begin
            ar_seen++;
            ar_cycle.push_back(cyc);
            if (exp_ar.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL ar_unexpected: got araddr %h want none", m_axi_araddr);
            end else begin
                a = exp_ar.pop_front();
                chk("araddr", m_axi_araddr, a.addr);
                chk("arlen", 32'(m_axi_arlen), 32'(a.len));
                chk("arburst", 32'(m_axi_arburst), 32'(a.burst));
                chk("arsize", 32'(m_axi_arsize), 32'd2);
            end
        end
    end

    // Data monitor
    initial forever begin
        beat_t b;
        @(negedge clk);
        if (rst_n && data_out_valid && data_out_ready) begin
            d_seen++;
            if (exp_d.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL data_unexpected: got data %h want none", data_out);
            end else begin
                b = exp_d.pop_front();
                chk("data", data_out, b.data);
                chk("data_ch", 32'(data_out_ch), 32'(b.ch));
                chk("data_last", 32'(data_out_last), 32'(b.last));
                chk("data_err", 32'(data_out_err), 32'(b.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, k, d0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst_rready", 32'(m_axi_rready), 32'd0);
        chk("rst_dvalid", 32'(data_out_valid), 32'd0);
        chk("rst_dlast", 32'(data_out_last), 32'd0);
        chk("rst_derr", 32'(data_out_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: plain INCR split by burst length
        push_ar(32'h1000, 8'd15, 2'b01); push_ar(32'h1040, 8'd15, 2'b01); push_ar(32'h1080, 8'd7, 2'b01);
        push_beats(3'd2, 40, -1);
        send_cmd(3'd2, 32'h1000, 2'b01, 40);
        drain("t1");

        // 2: 4 KB boundary split
        push_ar(32'h0FF8, 8'd1, 2'b01); push_ar(32'h1000, 8'd7, 2'b01);
        push_beats(3'd1, 10, -1);
        send_cmd(3'd1, 32'h0FF8, 2'b01, 10);
        drain("t2");

        // 3: outstanding limit with R channel stalled
        base = ar_seen;
        r_en = 1'b0;
        push_ar(32'h3000, 8'd15, 2'b01); push_ar(32'h3040, 8'd15, 2'b01);
        push_ar(32'h3080, 8'd15, 2'b01); push_ar(32'h30C0, 8'd15, 2'b01);
        push_ar(32'h3100, 8'd15, 2'b01); push_ar(32'h3140, 8'd15, 2'b01);
        push_ar(32'h3180, 8'd3, 2'b01);
        push_beats(3'd4, 100, -1);
        send_cmd(3'd4, 32'h3000, 2'b01, 100);
        repeat (20) @(negedge clk);
        chk("t3_ar_count", 32'(ar_seen - base), 32'd4);
        chk("t3_arvalid_blocked", 32'(m_axi_arvalid), 32'd0);
        first_rlast_cyc = -1;
        r_en = 1'b1;
        k = 0;
        while (ar_seen < base + 5 && k < 1000) begin @(negedge clk); k++; end
        if (ar_seen < base + 5) begin n_cmp++; n_err++; $display("FAIL t3_5th_ar_timeout: got %0d ARs want 5", ar_seen - base); end
        else chk("t3_5th_ar_gap", 32'(ar_cycle[base + 4] - first_rlast_cyc), 32'd1);
        drain("t3");

        // 4: sticky error from beat 3, cleared for the next command
        err_at = exp_idx + 2;
        push_ar(32'h4000, 8'd15, 2'b01); push_ar(32'h4040, 8'd3, 2'b01);
        push_beats(3'd6, 20, 2);
        send_cmd(3'd6, 32'h4000, 2'b01, 20);
        push_ar(32'h5000, 8'd3, 2'b01);
        push_beats(3'd0, 4, -1);
        send_cmd(3'd0, 32'h5000, 2'b01, 4);
        drain("t4");
        err_at = -1;

        // 5: FIXED bursts, then a zero-beat command
        push_ar(32'h2000, 8'd15, 2'b00); push_ar(32'h2000, 8'd3, 2'b00);
        push_beats(3'd7, 20, -1);
        send_cmd(3'd7, 32'h2000, 2'b00, 20);
        drain("t5");
        base = ar_seen;
        send_cmd(3'd5, 32'h2400, 2'b01, 0);
        @(negedge clk);
        chk("t5_zero_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("t5_zero_no_ar", 32'(ar_seen - base), 32'd0);

        // 6: random backpressure, back-to-back commands (second uses burst 11 as INCR)
        rand_rdy = 1'b1;
        push_ar(32'h6000, 8'd15, 2'b01); push_ar(32'h6040, 8'd7, 2'b01);
        push_beats(3'd3, 24, -1);
        push_ar(32'h7FC0, 8'd15, 2'b01); push_ar(32'h8000, 8'd3, 2'b01);
        push_beats(3'd5, 20, -1);
        send_cmd(3'd3, 32'h6000, 2'b01, 24);
        send_cmd(3'd5, 32'h7FC0, 2'b11, 20);
        drain("t6");
        rand_rdy = 1'b0;

        // 6b: reset pulsed mid-burst
        push_ar(32'h9000, 8'd15, 2'b01); push_ar(32'h9040, 8'd15, 2'b01);
        push_ar(32'h9080, 8'd15, 2'b01); push_ar(32'h90C0, 8'd15, 2'b01);
        push_beats(3'd2, 64, -1);
        d0 = d_seen;
        send_cmd(3'd2, 32'h9000, 2'b01, 64);
        k = 0;
        while (d_seen < d0 + 3 && k < 1000) begin @(negedge clk); k++; end
        @(posedge clk); #2;
        chk("pre_rst_dvalid", 32'(data_out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("mid_rst_dvalid", 32'(data_out_valid), 32'd0);
        chk("mid_rst_rready", 32'(m_axi_rready), 32'd0);
        burst_q.delete(); exp_ar.delete(); exp_d.delete();
        cur_rem = 0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        exp_idx = r_idx;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        push_ar(32'hA000, 8'd3, 2'b01);
        push_beats(3'd1, 4, -1);
        send_cmd(3'd1, 32'hA000, 2'b01, 4);
        drain("t6_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmac_read_mc.md
Name: dmac_read_mc

Overview:
Parametrised read engine for the DMA controller, successor to the fixed single-stream read path. Accepts channel-tagged read commands and splits them into AXI4 bursts limited by MAX_BURST_LEN and 4 KB boundaries. Keeps up to MAX_OUTSTANDING bursts in flight and returns read data tagged with channel, command-final-last and sticky error. Sits between the channel arbiter and the AXI read master port; feeds the write side.

Parameters:
ADDR_WD, 32, address width
DATA_WD, 32, data width (power of 2, 32..1024); STRB_WD = DATA_WD/8
CHANNEL_COUNT, 8, channels; CH_WD = max(1,$clog2(CHANNEL_COUNT))
MAX_BURST_LEN, 16, max beats per AR (1..256; FIXED bursts capped at 16)
MAX_OUTSTANDING, 4, max ARs issued whose rlast has not yet been returned (power of 2, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_ch  in  CH_WD  channel tag
cmd_src_addr  in  ADDR_WD  start address; low $clog2(STRB_WD) bits ignored (forced 0)
cmd_burst  in  2  01 INCR, 00 FIXED; other values treated as INCR
cmd_beats  in  ADDR_WD  total beats; 0 = accept and discard
data_out_valid  out  1  data valid
data_out_ready  in  1  data ready
data_out  out  DATA_WD  read data
data_out_ch  out  CH_WD  channel of beat
data_out_last  out  1  last beat of whole command
data_out_err  out  1  SLVERR/DECERR seen so far in this command, including this beat
m_axi_arvalid/araddr/arlen/arsize/arburst/arready  out/out/out/out/out/in  1/ADDR_WD/8/3/2/1  AXI4 AR
m_axi_rvalid/rdata/rresp/rlast/rready  in/in/in/in/out  1/DATA_WD/2/1/1  AXI4 R

Behaviour:
- Reset (async assert): state IDLE, all counters and FIFO empty; cmd_ready=1, arvalid=0, rready=0, data_out_valid=0, data_out_last=0, data_out_err=0. Reset mid-operation discards all in-flight state; arvalid drops immediately.
- FSM IDLE/ISSUE. cmd_ready = (state==IDLE). Handshake in IDLE latches addr, remaining=cmd_beats, burst, ch. If cmd_beats!=0 -> ISSUE, else stay IDLE with no output.
- ISSUE: arvalid = (fifo_count < MAX_OUTSTANDING). First arvalid is the cycle after cmd handshake.
- Beats n = min(remaining, MAX_BURST_LEN, B4K). B4K = (4096 - addr[11:0])/STRB_WD for INCR, infinite for FIXED; FIXED uses min(MAX_BURST_LEN,16).
- AR fields: arlen=n-1, arsize=$clog2(STRB_WD), arburst=01 or 00, araddr=addr. All stable while arvalid && !arready.
- AR handshake:
  - INCR: addr += n*STRB_WD.
  - remaining -= n.
  - Push {ch, final=(remaining==n)} into tag FIFO (depth MAX_OUTSTANDING).
  - If final -> IDLE. Next command may be accepted the following cycle while earlier bursts are still returning.
- R path: responses in order (single ID).
  - data_out_valid = rvalid && !fifo_empty; rready = data_out_ready && !fifo_empty.
  - data_out = rdata; data_out_ch = head.ch; data_out_last = rlast && head.final.
  - data_out_err = err_sticky | rresp[1].
- Beat transfer: if rresp[1], set err_sticky. On data_out_last transfer, clear err_sticky (clear wins). On rlast transfer, pop FIFO.
- Simultaneous FIFO push and pop leaves fifo_count unchanged. A pop in the same cycle as a full FIFO does not unblock arvalid until the next cycle (count is registered).
- rvalid with an empty FIFO is a protocol violation: rready stays 0.

Test Plan:
1. DATA_WD=32, INCR, addr 0x1000, beats 40, arready=1 -> AR (0x1000,arlen 15),(0x1040,15),(0x1080,7), arsize 2. data_out_last only on beat 40; data_out_ch = cmd_ch on all beats.
2. INCR addr 0x0FF8, beats 10 -> AR (0x0FF8,arlen 1),(0x1000,arlen 7). rlast of the first burst does not raise data_out_last.
3. Outstanding limit: rvalid=0, beats 100 -> exactly 4 ARs, then arvalid=0. After the first burst's rlast transfers, the 5th AR appears the following cycle.
4. 20-beat command, rresp=2 on beat 3 only -> data_out_err 0 on beats 1-2, 1 on beats 3-20. Next command's beats show data_out_err=0.
5. FIXED addr 0x2000, beats 20 -> AR (0x2000,arlen 15),(0x2000,arlen 3), arburst 00. Then cmd_beats=0 -> cmd_ready stays 1, no AR issued.
6. data_out_ready toggled randomly with two back-to-back commands (ch 3, ch 5) -> no beat lost or duplicated, tags correct. rst_n pulsed mid-burst -> arvalid, data_out_valid and rready are 0 in the same cycle; cmd_ready=1 after release.
